mfp_ahb_gpio_serial_out: RTL and testbench
==========================================

Name: mfp_ahb_gpio_serial_out

Overview:
Downstream consumer of the GPIO block's parallel output registers (LED / 7-segment words). It serialises a parallel word onto the SWORD board's external 74HC595-style shift-register chain using three signals: serial clock, serial data, and latch. A new transfer starts automatically whenever the parallel input differs from the last word shifted out, so firmware writes to the GPIO registers appear on the board without software handshaking. One instance is used per chain (LED chain, 7-segment chain).

Parameters:
N_BITS, 64, width of parallel word / length of external chain (2..256)
CLK_DIV, 4, HCLK cycles per sclk half-period (>=1)
INVERT, 0, 1 = XOR every bit with 1 before shifting (active-low segments)

Ports:
HCLK  input  1  system clock
HRESETn  input  1  asynchronous active-low reset
par_data  input  N_BITS  parallel word from GPIO output register
force  input  1  single-cycle pulse: request re-send even if data unchanged
sclk  output  1  serial clock to chain; data sampled by chain on rising edge
sdata  output  1  serial data, MSB (par_data[N_BITS-1]) first
slatch  output  1  storage-register latch pulse, active high
busy  output  1  high from capture through end of latch

Behaviour:
- Reset is HRESETn, asynchronous, active-low; clock is HCLK.
- All state is asynchronously reset: sclk=0, sdata=0, slatch=0, busy=0, last_sent=0, pending=1. Pending=1 guarantees one transfer after reset, so the chain holds defined content.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE: start condition = pending | force | (par_data != last_sent).
  - On start, in the same edge: shreg <= par_data ^ {N_BITS{INVERT}}; snap <= par_data; bitcnt <= N_BITS; divcnt <= CLK_DIV-1; pending <= 0; busy <= 1; go to SHIFT_LO.
  - Latency: par_data change at edge t means busy=1 after edge t+1.
- SHIFT_LO: sclk=0; sdata=shreg[N_BITS-1] (registered, stable for the whole low phase).
  - When divcnt reaches 0: go to SHIFT_HI and reload divcnt.
- SHIFT_HI: sclk=1 for CLK_DIV cycles.
  - At the end of the phase: shreg shifts left by 1 (zero fill) and bitcnt decrements.
  - If bitcnt was 1: go to LATCH with sclk=0. Otherwise go to SHIFT_LO.
- LATCH: sclk=0; slatch=1 for CLK_DIV cycles.
  - Then: slatch=0; last_sent <= snap; busy=0; go to IDLE.
- Transfer length: exactly N_BITS rising sclk edges and one latch pulse. Busy lasts 2*CLK_DIV*N_BITS + CLK_DIV cycles.
- sdata only changes while sclk=0. Setup and hold to the rising sclk edge are each at least CLK_DIV HCLK cycles.
- par_data changing mid-transfer: the in-flight word (snap) is not disturbed. In IDLE, last_sent != par_data triggers an immediate new transfer; at most one extra transfer results, never a partial one.
- force asserted while busy: sets pending. Exactly one re-send follows completion; multiple force pulses coalesce into one.
- force in IDLE together with a data change: a single transfer.
- Reset asserted mid-transfer: outputs return to reset values immediately. The chain keeps stale latched content until the post-reset transfer.
- Counter widths: divcnt is $clog2(CLK_DIV) bits (min 1); bitcnt is $clog2(N_BITS+1) bits. No wrap: counters are reloaded, never free-run.

Decomposition:
- Shared constants file gets MFP_SER_DIV default and the state encodings (2-bit localparams IDLE=0, SHIFT_LO=1, SHIFT_HI=2, LATCH=3).
- Chain widths reuse the existing MFP_N_LED / MFP_N_7SEG defines at instantiation.
- One natural sub-module: mfp_ser_clkdiv (divcnt and phase-done strobe), reused for both the shift and latch phases.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset release, par_data=0, N_BITS=8, CLK_DIV=2 -> one transfer of 8 zero bits, 8 sclk rising edges, slatch high 2 cycles; busy high exactly 2*2*8+2=34 cycles, then IDLE.
- par_data=8'hA5 in IDLE -> sdata sampled at rising sclk = 1,0,1,0,0,1,0,1; one slatch pulse; then no further activity while par_data is held.
- INVERT=1, par_data=8'hF0 -> sampled bits 0,0,0,0,1,1,1,1.
- par_data 8'h01 -> 8'h80 during bit 3 of a transfer -> first transfer completes with 8'h01; a second transfer of 8'h80 starts one cycle after busy falls; exactly two latch pulses.
- Three force pulses while busy with constant data -> exactly one additional transfer; force in IDLE with unchanged data -> one transfer.
- HRESETn asserted mid-SHIFT_HI -> sclk, sdata, slatch, busy = 0 asynchronously; after release, a full transfer of the current par_data.

Source files
------------

// File: rtl/mfp_ahb_gpio_serial_out_pkg.sv
// ---------------------------------------------------------------------------
// mfp_ahb_gpio_serial_out_pkg
//   Shared constants for the GPIO serial-out chain drivers.
//   - MFP_SER_DIV : default HCLK cycles per serial-clock half period
//   - ser_state_t : serialiser FSM encoding, also exported on the debug port
//   - ser_busy_cycles : length of one complete transfer in HCLK cycles
// ---------------------------------------------------------------------------
package mfp_ahb_gpio_serial_out_pkg;

   localparam int MFP_SER_DIV = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LATCH    = 2'd3
   } ser_state_t;

   // N_BITS low+high clock phases plus one latch phase.
   function automatic int ser_busy_cycles(input int n_bits, input int clk_div);
      return 2 * clk_div * n_bits + clk_div;
   endfunction

endpackage

// File: rtl/mfp_ahb_gpio_serial_out_if.sv
// ---------------------------------------------------------------------------
// mfp_ahb_gpio_serial_out_if
//   Bundles the parallel-word side and the serial chain side of one
//   serial-out instance.
//   - par_data   : parallel word from the GPIO output register
//   - force_send : one-cycle re-send request ("force" is a reserved word)
//   - sclk       : serial clock, chain samples sdata on its rising edge
//   - sdata      : serial data, MSB first
//   - slatch     : storage-register latch pulse, active high
//   - busy       : high from word capture through the end of the latch pulse
//
// Handshake: there is no valid/ready pair. The word is level-sampled: any
// difference from the last word shifted out starts a transfer when idle.
// force_send is a single-cycle request that is never dropped: if it arrives
// while busy it is remembered and served by exactly one extra transfer.
// busy is pure status and needs no acknowledge.
// ---------------------------------------------------------------------------
interface mfp_ahb_gpio_serial_out_if #(
   parameter int N_BITS = 64
);
   logic [N_BITS-1:0] par_data;
   logic              force_send;
   logic              sclk;
   logic              sdata;
   logic              slatch;
   logic              busy;

   modport master (
      output par_data, force_send,
      input  sclk, sdata, slatch, busy
   );

   modport slave (
      input  par_data, force_send,
      output sclk, sdata, slatch, busy
   );
endinterface

// File: rtl/mfp_ser_clkdiv.sv
// ---------------------------------------------------------------------------
// mfp_ser_clkdiv
//   Phase timer shared by the low, high and latch phases of the serialiser.
//   Loading sets the counter to CLK_DIV-1; it then counts down to zero and
//   holds there. done is high while the counter is zero, so a phase entered
//   by a load lasts exactly CLK_DIV cycles.
//   Ports:
//   - HCLK, HRESETn : clock, asynchronous active-low reset
//   - load          : restart the phase timer
//   - done          : current phase ends on this clock edge
// ---------------------------------------------------------------------------
module mfp_ser_clkdiv
   import mfp_ahb_gpio_serial_out_pkg::*;
#(
   parameter int CLK_DIV = MFP_SER_DIV
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic load,
   output logic done
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV - 1);

   logic [DW-1:0] divcnt;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         divcnt <= '0;
      end else if (load) begin
         divcnt <= RELOAD;
      end else if (divcnt != '0) begin
         divcnt <= divcnt - DW'(1);
      end
   end

   assign done = (divcnt == '0);

endmodule

// File: rtl/mfp_ahb_gpio_serial_out.sv
// ---------------------------------------------------------------------------
// mfp_ahb_gpio_serial_out
//   Serialises a parallel GPIO output word onto an external 74HC595-style
//   shift-register chain (sclk / sdata / slatch). A transfer starts on its
//   own whenever the word differs from the last one latched, on a re-send
//   request, and once after reset so the chain holds defined content.
//   Ports:
//   - HCLK, HRESETn : clock, asynchronous active-low reset
//   - bus           : slave side of mfp_ahb_gpio_serial_out_if
//   - dbg_state     : current serialiser state
//   Parameters:
//   - N_BITS  : word width / chain length (2..256)
//   - CLK_DIV : HCLK cycles per sclk half period (>= 1)
//   - INVERT  : complement every bit before shifting (active-low segments)
// ---------------------------------------------------------------------------
module mfp_ahb_gpio_serial_out
   import mfp_ahb_gpio_serial_out_pkg::*;
#(
   parameter int N_BITS  = 64,
   parameter int CLK_DIV = MFP_SER_DIV,
   parameter bit INVERT  = 1'b0
) (
   input  logic                        HCLK,
   input  logic                        HRESETn,
   mfp_ahb_gpio_serial_out_if.slave    bus,
   output ser_state_t                  dbg_state
);

   localparam int BW = $clog2(N_BITS + 1);

   ser_state_t        state;
   logic [N_BITS-1:0] shreg;
   logic [N_BITS-1:0] snap;
   logic [N_BITS-1:0] last_sent;
   logic [BW-1:0]     bitcnt;
   logic              pending;
   logic              sclk_q;
   logic              sdata_q;
   logic              slatch_q;
   logic              busy_q;

   logic              start;
   logic              div_load;
   logic              phase_done;
   logic [N_BITS-1:0] shreg_shift;

   assign start = (state == IDLE) &&
                  (pending || bus.force_send || (bus.par_data != last_sent));

   // Every non-idle phase is timed by the same divider; restart it on
   // capture and at every phase boundary.
   assign div_load = start || ((state != IDLE) && phase_done);

   assign shreg_shift = {shreg[N_BITS-2:0], 1'b0};

   mfp_ser_clkdiv #(
      .CLK_DIV (CLK_DIV)
   ) u_clkdiv (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .load    (div_load),
      .done    (phase_done)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= IDLE;
         shreg     <= '0;
         snap      <= '0;
         last_sent <= '0;
         bitcnt    <= '0;
         pending   <= 1'b1;
         sclk_q    <= 1'b0;
         sdata_q   <= 1'b0;
         slatch_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg   <= bus.par_data ^ {N_BITS{INVERT}};
                  sdata_q <= bus.par_data[N_BITS-1] ^ INVERT;
                  snap    <= bus.par_data;
                  bitcnt  <= BW'(N_BITS);
                  pending <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (phase_done) begin
                  sclk_q <= 1'b1;
                  state  <= SHIFT_HI;
               end
            end
            SHIFT_HI: begin
               if (phase_done) begin
                  // sdata moves together with the falling sclk edge, so it
                  // is stable for a full half period either side of a rise.
                  // After the last bit the zero fill drives sdata low.
                  sclk_q  <= 1'b0;
                  shreg   <= shreg_shift;
                  sdata_q <= shreg[N_BITS-2];
                  bitcnt  <= bitcnt - BW'(1);
                  if (bitcnt == BW'(1)) begin
                     slatch_q <= 1'b1;
                     state    <= LATCH;
                  end else begin
                     state    <= SHIFT_LO;
                  end
               end
            end
            LATCH: begin
               if (phase_done) begin
                  slatch_q  <= 1'b0;
                  last_sent <= snap;
                  busy_q    <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // A re-send request during a transfer is held until the next idle
         // cycle; repeated requests collapse into one.
         if ((state != IDLE) && bus.force_send) begin
            pending <= 1'b1;
         end
      end
   end

   assign bus.sclk   = sclk_q;
   assign bus.sdata  = sdata_q;
   assign bus.slatch = slatch_q;
   assign bus.busy   = busy_q;
   assign dbg_state  = state;

endmodule

// File: tb/tb_mfp_ahb_gpio_serial_out.sv
// ---------------------------------------------------------------------------
// tb_mfp_ahb_gpio_serial_out
//   Two 8-bit, CLK_DIV=2 instances (plain and inverted) driven with the same
//   parallel word and re-send requests. A monitor rebuilds each latched word
//   from sdata at rising sclk and measures busy / latch lengths; the words
//   are compared against a queue of expected transfers kept by the stimulus.
// ---------------------------------------------------------------------------
module tb_mfp_ahb_gpio_serial_out;
   import mfp_ahb_gpio_serial_out_pkg::*;

   localparam int N        = 8;
   localparam int CD       = 2;
   localparam int BUSY_CYC = 2 * CD * N + CD;
   localparam logic [N-1:0] INV_MASK = '1;

   // ---------------- clock / reset ----------------
   logic HCLK;
   logic HRESETn;

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // ---------------- DUTs ----------------
   logic [N-1:0] par_data;
   logic         force_send;
   ser_state_t   dbg0;
   ser_state_t   dbg1;

   mfp_ahb_gpio_serial_out_if #(.N_BITS(N)) bus0 ();
   mfp_ahb_gpio_serial_out_if #(.N_BITS(N)) bus1 ();

   assign bus0.par_data   = par_data;
   assign bus0.force_send = force_send;
   assign bus1.par_data   = par_data;
   assign bus1.force_send = force_send;

   mfp_ahb_gpio_serial_out #(.N_BITS(N), .CLK_DIV(CD), .INVERT(1'b0)) dut0 (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .bus       (bus0),
      .dbg_state (dbg0)
   );

   mfp_ahb_gpio_serial_out #(.N_BITS(N), .CLK_DIV(CD), .INVERT(1'b1)) dut1 (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .bus       (bus1),
      .dbg_state (dbg1)
   );

   logic sclk_a   [2];
   logic sdata_a  [2];
   logic slatch_a [2];
   logic busy_a   [2];

   assign sclk_a[0]   = bus0.sclk;
   assign sclk_a[1]   = bus1.sclk;
   assign sdata_a[0]  = bus0.sdata;
   assign sdata_a[1]  = bus1.sdata;
   assign slatch_a[0] = bus0.slatch;
   assign slatch_a[1] = bus1.slatch;
   assign busy_a[0]   = bus0.busy;
   assign busy_a[1]   = bus1.busy;

   // ---------------- scoreboard ----------------
   logic [N-1:0] exp_q[$];
   int           exp_total;
   logic [N-1:0] model_last;
   int           n_checks;
   int           n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic expect_word(input logic [N-1:0] w);
      exp_q.push_back(w);
      exp_total++;
   endtask

   // ---------------- monitor ----------------
   logic         prev_sclk  [2];
   logic         prev_sdata [2];
   logic         prev_latch [2];
   logic         prev_busy  [2];
   logic [N-1:0] shift_a    [2];
   int           nbits      [2];
   int           latch_len  [2];
   int           busy_len   [2];
   int           n_xfer     [2];
   int           gap_cnt;
   int           last_gap;
   logic         mon_latch;

   always @(negedge HCLK) begin
      mon_latch = 1'b0;
      if (!HRESETn) begin
         for (int i = 0; i < 2; i++) begin
            prev_sclk[i]  = 1'b0;
            prev_sdata[i] = 1'b0;
            prev_latch[i] = 1'b0;
            prev_busy[i]  = 1'b0;
            shift_a[i]    = '0;
            nbits[i]      = 0;
            latch_len[i]  = 0;
            busy_len[i]   = 0;
         end
         gap_cnt = 0;
      end else begin
         if (busy_a[0] && !prev_busy[0]) begin
            last_gap = gap_cnt;
            gap_cnt  = 0;
         end else if (!busy_a[0]) begin
            gap_cnt++;
         end
         for (int i = 0; i < 2; i++) begin
            if (sclk_a[i] && !prev_sclk[i]) begin
               shift_a[i] = {shift_a[i][N-2:0], sdata_a[i]};
               nbits[i]++;
            end
            if (sclk_a[i] && prev_sclk[i])
               check("sdata_hold_high", sdata_a[i], prev_sdata[i]);
            if (slatch_a[i])
               latch_len[i]++;
            if (!slatch_a[i] && prev_latch[i]) begin
               check("latch_len", latch_len[i], CD);
               check("bit_count", nbits[i], N);
               check("xfer_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0)
                  check(i == 0 ? "word_plain" : "word_invert", shift_a[i],
                        exp_q[0] ^ ((i == 1) ? INV_MASK : '0));
               mon_latch    = 1'b1;
               n_xfer[i]++;
               nbits[i]     = 0;
               latch_len[i] = 0;
            end
            if (busy_a[i])
               busy_len[i]++;
            if (!busy_a[i] && prev_busy[i]) begin
               check("busy_len", busy_len[i], BUSY_CYC);
               busy_len[i] = 0;
            end
            prev_sclk[i]  = sclk_a[i];
            prev_sdata[i] = sdata_a[i];
            prev_latch[i] = slatch_a[i];
            prev_busy[i]  = busy_a[i];
         end
         if (mon_latch && exp_q.size() != 0)
            void'(exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [N-1:0] new_word();
      logic [N-1:0] d;
      d = N'($urandom_range(1, (1 << N) - 1));
      return model_last ^ d;
   endfunction

   task automatic quiet(input string tag, input int cycles);
      repeat (cycles) @(negedge HCLK);
      check({tag, "_idle"}, bus0.busy, 0);
      check({tag, "_count"}, n_xfer[0], exp_total);
      check({tag, "_count_inv"}, n_xfer[1], exp_total);
   endtask

   task automatic settle(input string tag);
      for (int i = 0; i < 600 && n_xfer[0] < exp_total; i++) @(negedge HCLK);
      check({tag, "_done"}, n_xfer[0] >= exp_total, 1);
      quiet(tag, 6);
   endtask

   task automatic write_idle(input string tag, input logic [N-1:0] w);
      @(negedge HCLK);
      par_data = w;
      if (w != model_last) begin
         expect_word(w);
         model_last = w;
         @(posedge HCLK); #1;
         check({tag, "_start_latency"}, bus0.busy, 1);
      end
      settle(tag);
   endtask

   task automatic mid_change(input string tag, input logic [N-1:0] w1,
                             input logic [N-1:0] w2, input int k);
      @(negedge HCLK);
      par_data = w1;
      expect_word(w1);
      model_last = w1;
      for (int i = 0; i < 200 && nbits[0] < k; i++) @(posedge HCLK);
      @(negedge HCLK);
      check({tag, "_in_flight"}, bus0.busy, 1);
      par_data = w2;
      if (w2 != w1) begin
         expect_word(w2);
         model_last = w2;
      end
      settle(tag);
      if (w2 != w1) check({tag, "_gap"}, last_gap, 1);
   endtask

   task automatic pulse_force();
      @(negedge HCLK);
      force_send = 1'b1;
      @(negedge HCLK);
      force_send = 1'b0;
   endtask

   task automatic force_busy(input string tag, input int n);
      logic [N-1:0] w;
      w = new_word();
      @(negedge HCLK);
      par_data = w;
      expect_word(w);
      model_last = w;
      for (int p = 0; p < n; p++) begin
         repeat ($urandom_range(1, 6)) @(negedge HCLK);
         pulse_force();
      end
      check({tag, "_still_busy"}, bus0.busy, 1);
      expect_word(w);
      settle(tag);
      check({tag, "_gap"}, last_gap, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [N-1:0] w;
      HRESETn    = 1'b0;
      par_data   = '0;
      force_send = 1'b0;
      model_last = '0;
      repeat (3) @(negedge HCLK);
      check("rst_sclk",    bus0.sclk,   0);
      check("rst_sdata",   bus0.sdata,  0);
      check("rst_slatch",  bus0.slatch, 0);
      check("rst_busy",    bus0.busy,   0);
      check("rst_busy_inv", bus1.busy,  0);
      check("rst_sdata_inv", bus1.sdata, 0);
      check("rst_state",   dbg0, IDLE);

      // Reset leaves a pending transfer of the current word.
      expect_word('0);
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      check("post_reset_start", bus0.busy, 1);
      settle("post_reset");

      write_idle("a5", 8'hA5);
      quiet("a5_hold", 20);
      write_idle("same_word", 8'hA5);
      write_idle("f0", 8'hF0);

      mid_change("mid_01_80", 8'h01, 8'h80, 3);

      force_busy("force3", 3);

      pulse_force();
      check("force_idle_start", bus0.busy, 1);
      expect_word(model_last);
      settle("force_idle");

      w = new_word();
      @(negedge HCLK);
      par_data   = w;
      force_send = 1'b1;
      @(negedge HCLK);
      force_send = 1'b0;
      expect_word(w);
      model_last = w;
      settle("force_and_data");

      for (int r = 0; r < 6; r++) begin
         case ($urandom_range(0, 2))
            0: write_idle("rnd_idle", ($urandom_range(0, 3) == 0) ? model_last : new_word());
            1: mid_change("rnd_mid", new_word(), N'($urandom), $urandom_range(1, 7));
            default: force_busy("rnd_force", $urandom_range(1, 3));
         endcase
      end

      // Reset in the middle of a high phase.
      w = new_word();
      @(negedge HCLK);
      par_data = w;
      expect_word(w);
      model_last = w;
      for (int i = 0; i < 400; i++) begin
         @(posedge HCLK); #1;
         if (dbg0 == SHIFT_HI && nbits[0] >= 2) break;
      end
      check("mid_reset_reached", dbg0, SHIFT_HI);
      HRESETn = 1'b0;
      #1;
      check("mid_rst_sclk",   bus0.sclk,   0);
      check("mid_rst_sdata",  bus0.sdata,  0);
      check("mid_rst_slatch", bus0.slatch, 0);
      check("mid_rst_busy",   bus0.busy,   0);
      check("mid_rst_sclk_inv", bus1.sclk, 0);
      check("mid_rst_state",  dbg0, IDLE);
      exp_q.delete();
      exp_total--;
      expect_word(w);
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      check("mid_rst_restart", bus0.busy, 1);
      settle("mid_rst");

      check("exp_q_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
